// File: rtl/fc_bram_port_arb.sv
// ---------------------------------------------------------------------------
// fc_bram_port_arb
//
// Shares the single 32-bit port B of the FC scratch BRAM between the encoder
// FC layer controller (requester 0) and the decoder FC layer controller
// (requester 1). Port A of the BRAM stays on the AXI BRAM controller.
//
// Arbitration is round-robin with burst lock: a granted requester keeps the
// port while it holds its request, but once the other side is waiting it is
// preempted after MAX_BURST enabled beats. Read beats are tagged with their
// owner so read data returns to the right requester RD_LAT cycles later, even
// when the grant has moved on in the meantime.
//
// Optional build macro: FC_ARB_STATS_EN adds the wait_cnt0/wait_cnt1 and
// preempt_cnt statistics outputs. Without it those ports do not exist and
// arbitration / read return behave identically.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0/req1                 access request, held for the whole burst
//   gnt0/gnt1                 registered grant, one-hot or zero
//   en0/en1, we0/we1          beat enable / write enable (ignored unless granted)
//   addr0/addr1, din0/din1    beat address / write data
//   dout                      BRAM read data, broadcast to both requesters
//   rvld0/rvld1               dout valid for requester 0 / 1
//   bram_en/we/addr/din       BRAM port B drive (combinational mux)
//   bram_dout                 BRAM port B read data
//   wait_cnt0/1, preempt_cnt  statistics (FC_ARB_STATS_EN builds only)
// ---------------------------------------------------------------------------
module fc_bram_port_arb #(
    parameter int ADDR_W    = 12,
    parameter int DAT_W     = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              en0,
    input  logic              en1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DAT_W-1:0]  din0,
    input  logic [DAT_W-1:0]  din1,
    output logic [DAT_W-1:0]  dout,
    output logic              rvld0,
    output logic              rvld1,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DAT_W-1:0]  bram_din,
    input  logic [DAT_W-1:0]  bram_dout
`ifdef FC_ARB_STATS_EN
    ,
    output logic [15:0]       wait_cnt0,
    output logic [15:0]       wait_cnt1,
    output logic [15:0]       preempt_cnt
`endif
);

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t            state;
    logic              last;
    logic [CNT_W-1:0]  beat_cnt;
    logic              burst_full;
    logic              preempt;
    logic              rd_issue;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);

    // The holder has used up its burst allowance; with the other side waiting,
    // the next enabled beat is its last one before the grant moves over.
    assign burst_full = (beat_cnt == CNT_MAX);
    assign preempt    = ((state == G0) && req0 && req1 && en0 && burst_full) ||
                        ((state == G1) && req1 && req0 && en1 && burst_full);

    // Grant FSM. beat_cnt saturates at MAX_BURST-1 so a long uncontested
    // burst still triggers preemption on its very next beat once the other
    // requester shows up. 'last' remembers who held the port most recently
    // so a simultaneous request from IDLE goes to the other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (req0 && req1) state <= last ? G0 : G1;
                    else if (req0)    state <= G0;
                    else if (req1)    state <= G1;
                end
                G0: begin
                    if (!req0 || preempt) begin
                        state    <= req1 ? G1 : IDLE;
                        last     <= 1'b0;
                        beat_cnt <= '0;
                    end else if (en0 && !burst_full) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                G1: begin
                    if (!req1 || preempt) begin
                        state    <= req0 ? G0 : IDLE;
                        last     <= 1'b1;
                        beat_cnt <= '0;
                    end else if (en1 && !burst_full) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // BRAM port mux: the grant is live in the cycle it is high, so the
    // granted requester's beat goes straight to the port with no extra stage.
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        unique case (state)
            G0: begin
                bram_en   = en0;
                bram_we   = en0 & we0;
                bram_addr = addr0;
                bram_din  = din0;
            end
            G1: begin
                bram_en   = en1;
                bram_we   = en1 & we1;
                bram_addr = addr1;
                bram_din  = din1;
            end
            default: ;
        endcase
    end

    assign rd_issue = bram_en & ~bram_we;

    // Read tag pipe, one stage per cycle of BRAM latency. The owner is
    // captured at issue time, so reads still in flight when the grant
    // switches return to whoever issued them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= rd_issue;
            tag_own[0] <= (state == G1);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    assign rvld0 = tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
    assign rvld1 = tag_vld[RD_LAT-1] &  tag_own[RD_LAT-1];
    assign dout  = bram_dout;

`ifdef FC_ARB_STATS_EN
    // Statistics: cycles spent waiting with a request up but no grant, and
    // the number of burst-cap preemptions. All saturate at 0xFFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt0   <= '0;
            wait_cnt1   <= '0;
            preempt_cnt <= '0;
        end else begin
            if (req0 && !gnt0 && (wait_cnt0 != 16'hFFFF))
                wait_cnt0 <= wait_cnt0 + 16'd1;
            if (req1 && !gnt1 && (wait_cnt1 != 16'hFFFF))
                wait_cnt1 <= wait_cnt1 + 16'd1;
            if (preempt && (preempt_cnt != 16'hFFFF))
                preempt_cnt <= preempt_cnt + 16'd1;
        end
    end
`endif

endmodule
